// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message packer.
// Holds the FSM state encoding and the block geometry.
package sha256_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    PRESENT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int          MAX_MSG_BYTES = 55;
  localparam logic [7:0]  PAD_BYTE      = 8'h80;
  localparam int          BLOCK_WORDS   = 14;
  localparam int          BLOCK_BYTES   = BLOCK_WORDS * 4;

endpackage

// File: rtl/sha256_msg_packer.sv
// Packs a byte stream into the first 14 words of a SHA-256 block; 2-cycle tlast->string_dv latency.
// Holds the block until string_ready; oversize frames are drained and flagged. Option: SHA256_PACKER_PAD_EN.
module sha256_msg_packer
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES = MAX_MSG_BYTES
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [BLOCK_WORDS*32-1:0] string_data,
  output logic [7:0]                string_size,
  output logic                      string_dv,
  input  logic                      string_ready,
  output logic                      err_oversize
);

  localparam logic [5:0] MAX_CNT  = 6'(MAX_BYTES);
  localparam logic [5:0] TOP_BYTE = 6'(BLOCK_BYTES - 1);

  state_t                      state_q, state_d;
  logic [BLOCK_BYTES-1:0][7:0] msg_q;
  logic [5:0]                  cnt_q;
  logic [7:0]                  size_q;
  logic                        err_q;
  logic                        rst_done_q;

  logic       tready_c;
  logic       wr_byte;
  logic       pad_wr;
  logic       clr;
  logic       err_set;
  logic [5:0] idx;

  // Byte 0 lives in the most significant lane of the packed buffer.
  assign idx = TOP_BYTE - cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tready_c = 1'b0;
    wr_byte  = 1'b0;
    pad_wr   = 1'b0;
    clr      = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      COLLECT: begin
        tready_c = rst_done_q;
        if (s_axis_tvalid && rst_done_q) begin
          if (cnt_q == MAX_CNT) begin
            // One byte past the limit: the frame is oversize, drop it.
            clr = 1'b1;
            if (s_axis_tlast) begin
              err_set = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            wr_byte = 1'b1;
            if (s_axis_tlast) begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        pad_wr  = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (string_ready) begin
          clr     = 1'b1;
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        tready_c = rst_done_q;
        if (s_axis_tvalid && rst_done_q && s_axis_tlast) begin
          err_set = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      msg_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      err_q      <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      err_q      <= err_set;
      if (clr) begin
        msg_q  <= '0;
        cnt_q  <= '0;
        size_q <= '0;
      end else begin
        if (wr_byte) begin
          msg_q[idx] <= s_axis_tdata;
          cnt_q      <= cnt_q + 6'd1;
        end
        if (pad_wr) begin
          size_q <= {2'b00, cnt_q};
`ifdef SHA256_PACKER_PAD_EN
          msg_q[idx] <= PAD_BYTE;
`endif
        end
      end
    end
  end

  assign s_axis_tready = tready_c;
  assign string_data   = msg_q;
  assign string_size   = size_q;
  assign string_dv     = (state_q == PRESENT);
  assign err_oversize  = err_q;

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Directed, table-driven bench for sha256_msg_packer; expected pad byte follows SHA256_PACKER_PAD_EN.
module tb_sha256_msg_packer;

`ifdef SHA256_PACKER_PAD_EN
  localparam logic [7:0] P = 8'h80;
`else
  localparam logic [7:0] P = 8'h00;
`endif

  typedef struct {
    int          len;
    logic [7:0]  start;
    logic [31:0] w0;
    logic [31:0] w13;
    logic [7:0]  size;
    bit          err;
  } vec_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [7:0]   s_axis_tdata = 8'h00;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [447:0] string_data;
  logic [7:0]   string_size;
  logic         string_dv;
  logic         string_ready = 1'b1;
  logic         err_oversize;

  int n_pass = 0;
  int n_total = 0;

  vec_t vecs[8];

  sha256_msg_packer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .string_data   (string_data),
    .string_size   (string_size),
    .string_dv     (string_dv),
    .string_ready  (string_ready),
    .err_oversize  (err_oversize)
  );

  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [447:0] act, input logic [447:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [447:0] build(input int len, input logic [7:0] start);
    logic [447:0] e;
    e = '0;
    for (int i = 0; i < len; i++) e[447-8*i -: 8] = start + 8'(i);
    e[447-8*len -: 8] = P;
    return e;
  endfunction

  task automatic wait_rdy(input string name);
    int g;
    g = 0;
    while (!s_axis_tready && g < 50) begin
      @(negedge aclk);
      g++;
    end
    check(name, s_axis_tready, 1);
  endtask

  task automatic send_bytes(input int len, input logic [7:0] start, input bit last_on_end);
    for (int i = 0; i < len; i++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = start + 8'(i);
      s_axis_tlast  = last_on_end && (i == len - 1);
      wait_rdy("tready_wait");
      @(posedge aclk);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int dv_first, dv_cnt, err_first, err_cnt;
    logic [447:0] got;
    logic [7:0] got_size;
    dv_first = 0; dv_cnt = 0; err_first = 0; err_cnt = 0;
    got = '0; got_size = '0;
    send_bytes(v.len, v.start, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      if (string_dv) begin
        dv_cnt++;
        if (dv_first == 0) dv_first = c;
        got = string_data;
        got_size = string_size;
      end
      if (err_oversize) begin
        err_cnt++;
        if (err_first == 0) err_first = c;
      end
    end
    if (v.err) begin
      check($sformatf("v%0d_err_count", k), err_cnt, 1);
      check($sformatf("v%0d_err_cycle", k), err_first, 1);
      check($sformatf("v%0d_no_dv", k), dv_cnt, 0);
    end else begin
      check($sformatf("v%0d_no_err", k), err_cnt, 0);
      check($sformatf("v%0d_dv_latency", k), dv_first, 2);
      check($sformatf("v%0d_dv_cycles", k), dv_cnt, 1);
      check($sformatf("v%0d_w0", k), got[447:416], v.w0);
      check($sformatf("v%0d_w13", k), got[31:0], v.w13);
      check($sformatf("v%0d_block", k), got, build(v.len, v.start));
      check($sformatf("v%0d_size", k), got_size, v.size);
    end
  endtask

  initial begin
    logic [447:0] held;
    int g;

    vecs[0] = '{3,  8'h61, {8'h61, 8'h62, 8'h63, P}, 32'h0, 8'd3, 1'b0};
    vecs[1] = '{55, 8'h00, 32'h00010203, {8'h34, 8'h35, 8'h36, P}, 8'd55, 1'b0};
    vecs[2] = '{56, 8'h00, 32'h0, 32'h0, 8'd0, 1'b1};
    vecs[3] = '{1,  8'hAA, {8'hAA, P, 16'h0000}, 32'h0, 8'd1, 1'b0};
    vecs[4] = '{4,  8'h10, 32'h10111213, 32'h0, 8'd4, 1'b0};
    vecs[5] = '{54, 8'h00, 32'h00010203, {8'h34, 8'h35, P, 8'h00}, 8'd54, 1'b0};
    vecs[6] = '{60, 8'h20, 32'h0, 32'h0, 8'd0, 1'b1};
    vecs[7] = '{2,  8'hF0, {8'hF0, 8'hF1, P, 8'h00}, 32'h0, 8'd2, 1'b0};

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_dv", string_dv, 0);
    check("rst_err", err_oversize, 0);
    check("rst_data", string_data, '0);
    check("rst_size", string_size, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_tready", s_axis_tready, 1);

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // Downstream stall: block held for 10 cycles, then handshake
    string_ready = 1'b0;
    send_bytes(3, 8'h61, 1'b1);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    g = 0;
    while (!string_dv && g < 10) begin
      @(negedge aclk);
      g++;
    end
    check("stall_dv_latency", g, 1);
    held = string_data;
    check("stall_block", held, build(3, 8'h61));
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge aclk);
      check($sformatf("stall_dv_c%0d", c), string_dv, 1);
      check($sformatf("stall_tready_c%0d", c), s_axis_tready, 0);
      check($sformatf("stall_data_c%0d", c), string_data, held);
      check($sformatf("stall_size_c%0d", c), string_size, 3);
    end
    string_ready = 1'b1;
    @(negedge aclk);
    check("stall_dv_fall", string_dv, 0);
    check("stall_tready_back", s_axis_tready, 1);
    check("stall_data_clr", string_data, '0);
    check("stall_size_clr", string_size, 0);

    // Reset mid-frame: partial frame lost, no error
    send_bytes(20, 8'h40, 1'b0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    check("midrst_tready", s_axis_tready, 0);
    check("midrst_data", string_data, '0);
    check("midrst_err", err_oversize, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_tready_back", s_axis_tready, 1);
    check("midrst_dv", string_dv, 0);
    run_vec(8, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sha256_msg_packer.md
SHA256_MSG_PACKER -- requirements
Module: sha256_msg_packer

Interface
REQ-001 Parameter MAX_BYTES, default 55: largest accepted message length in bytes; legal range is 1..55.
REQ-002 aclk  in  1  the single clock; all logic is rising-edge.
REQ-003 aresetn  in  1  reset, asynchronous and active-low.
REQ-004 s_axis_tdata  in  8  message byte, first byte of the message first.
REQ-005 s_axis_tvalid  in  1  byte valid.
REQ-006 s_axis_tready  out  1  byte accepted when tvalid and tready are both high.
REQ-007 s_axis_tlast  in  1  marks the final byte of the message.
REQ-008 string_data  out  448  message words w0..w13; w0 in [447:416], w13 in [31:0]; big-endian bytes within each word.
REQ-009 string_size  out  8  message length in bytes.
REQ-010 string_dv  out  1  block valid; level signal.
REQ-011 string_ready  in  1  downstream hash core is idle and can take a block.
REQ-012 err_oversize  out  1  one-cycle pulse when a message is dropped for exceeding MAX_BYTES.

Function
REQ-013 FSM states: COLLECT, PAD, PRESENT, DRAIN; reset state is COLLECT.
REQ-014 COLLECT:
- s_axis_tready=1.
- Each accepted byte is written at byte index cnt (byte 0 = string_data[447:440]).
- cnt increments by 1 per accepted byte.
REQ-015 In COLLECT, an accepted beat with tlast=1 and cnt<MAX_BYTES moves the FSM to PAD.
REQ-016 In COLLECT, an accepted beat with tlast=0 and cnt==MAX_BYTES-1 still stores the byte and moves the FSM to COLLECT-full, so the next beat decides:
- If that next beat is accepted in the full condition (cnt==MAX_BYTES), the FSM goes to DRAIN, clears the buffer and cnt, and discards the byte.
REQ-017 PAD (one cycle):
- s_axis_tready=0.
- Writes the pad byte at index cnt.
- string_size <= cnt.
- Next state is PRESENT.
REQ-018 PRESENT:
- s_axis_tready=0.
- string_dv=1, with string_data and string_size held stable.
REQ-019 In PRESENT, the handshake completes on the first cycle with string_dv && string_ready. On the following cycle:
- string_dv=0.
- The buffer is zeroed, cnt=0 and string_size=0.
- The FSM returns to COLLECT.
REQ-020 DRAIN:
- s_axis_tready=1 and every byte is discarded.
- An accepted tlast beat pulses err_oversize on the next cycle and returns the FSM to COLLECT.
REQ-021 Latency from the accepted tlast beat to string_dv=1 is exactly 2 cycles (PAD, then PRESENT).
REQ-022 string_dv never falls without a completed handshake; string_ready low holds PRESENT indefinitely.
REQ-023 Byte positions beyond the pad byte are always zero.
REQ-024 cnt is 6 bits and never wraps; the DRAIN transition prevents overflow.
REQ-025 tvalid is ignored whenever s_axis_tready=0.

Reset
REQ-026 Assertion of aresetn=0 at any time, including mid-frame or during PRESENT, sets:
- state=COLLECT.
- buffer=0, cnt=0, string_size=0.
- string_dv=0, err_oversize=0.
- s_axis_tready=0 while reset is asserted, then 1 from the first clock after release.
REQ-027 A partial frame interrupted by reset is lost with no error pulse.

Configuration
REQ-028 Macro SHA256_PACKER_PAD_EN:
- Defined: PAD writes 8'h80 at index cnt (SHA-256 padding bit).
- Undefined: PAD writes nothing (index cnt stays 0x00), for consumers that pad internally; the PAD cycle and all timing are retained.

Structure
REQ-029 Package sha256_pkg holds the FSM state enum, MAX_MSG_BYTES=55, PAD_BYTE=8'h80 and BLOCK_WORDS=14.
REQ-030 The block is a single module; no sub-module is natural because byte-lane writes and the FSM share the counter tightly.

Verification
REQ-031 Bytes "abc" (0x61,0x62,0x63, tlast on 0x63) with string_ready=1 -> string_data[447:416]=0x61626380, all other bits 0, string_size=3, string_dv high exactly 1 cycle, 2 cycles after the tlast beat.
REQ-032 55 bytes 0x00..0x36 -> w13=0x3435_3680, string_size=55, err_oversize=0.
REQ-033 56 bytes, tlast on byte 56 -> err_oversize one pulse, no string_dv; a following 1-byte message 0xAA -> w0=0xAA800000, string_size=1.
REQ-034 "abc" with string_ready=0 for 10 cycles -> string_dv and data stable for 10 cycles, s_axis_tready=0, handshake on cycle 11, tready=1 the cycle after.
REQ-035 aresetn pulsed low after 20 bytes, then "abc" -> only "abc" is presented; no error pulse.
REQ-036 SHA256_PACKER_PAD_EN undefined, "abc" -> w0=0x61626300, string_size=3, same timing as REQ-031.
